// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer bundle for sync_fifo_v2: write/read requests in, data plus status/occupancy out.
// master = the producer/consumer side, slave = the FIFO.
interface sync_fifo_v2_if #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic [CNT_W-1:0]      count;

   modport master (
      output data_in, wr_en, rd_en,
      input  data_out, wr_ack, overflow, underflow,
      input  full, empty, almostfull, almostempty, count
   );

   modport slave (
      input  data_in, wr_en, rd_en,
      output data_out, wr_ack, overflow, underflow,
      output full, empty, almostfull, almostempty, count
   );
endinterface

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO: 1-cycle registered read (first-word-fall-through when FIFO_FWFT_EN is defined),
// write visible after its edge; full rejects writes (overflow pulse), empty rejects reads (underflow pulse).
module sync_fifo_v2 #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input logic           clk,
   input logic           rst,
   sync_fifo_v2_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] AF_C       = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C       = CNT_W'(AE_LEVEL);
   localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(FIFO_DEPTH - 1);

   if (!(FIFO_WIDTH >= 1 && FIFO_DEPTH >= 2 && AE_LEVEL >= 1 &&
         AE_LEVEL < AF_LEVEL && AF_LEVEL <= FIFO_DEPTH - 1)) begin : g_bad_params
      $error("sync_fifo_v2: need 1 <= AE_LEVEL < AF_LEVEL <= FIFO_DEPTH-1, FIFO_DEPTH >= 2, FIFO_WIDTH >= 1");
   end

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;

   // Flags come straight from the registered count, so acceptance never depends
   // on this cycle's requests and no input reaches an output combinationally.
   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign wr_acc = bus.wr_en && !full;
   assign rd_acc = bus.rd_en && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_acc;
         overflow  <= bus.wr_en && full;
         underflow <= bus.rd_en && empty;

         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PTR_LAST_C) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PTR_LAST_C) ? '0 : rd_ptr + 1'b1;
         end

         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

`ifdef FIFO_FWFT_EN
   assign bus.data_out = empty ? '0 : mem[rd_ptr];
`else
   logic [FIFO_WIDTH-1:0] rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_acc) begin
         rd_data <= mem[rd_ptr];
      end
   end

   assign bus.data_out = rd_data;
`endif

   assign bus.wr_ack      = wr_ack;
   assign bus.overflow    = overflow;
   assign bus.underflow   = underflow;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almostfull  = (count >= AF_C) && !full;
   assign bus.almostempty = (count <= AE_C) && !empty;
   assign bus.count       = count;
endmodule

// File: tb/tb_sync_fifo_v2.sv
// Scoreboard bench: two FIFO configurations (8/7/1 and 5/3/2) share one stimulus stream; a queue model predicts each cycle.
module tb_sync_fifo_v2;
   typedef struct packed {
      logic [15:0] dout;
      logic [7:0]  cnt;
      logic        full;
      logic        empty;
      logic        af;
      logic        ae;
      logic        ack;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] data_in = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input int depth, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s depth=%0d t=%0t: got 0x%0h, expected 0x%0h", nm, depth, $time, act, req);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int DEPTH = (g == 0) ? 8 : 5;
      localparam int AF    = (g == 0) ? 7 : 3;
      localparam int AE    = (g == 0) ? 1 : 2;

      sync_fifo_v2_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH)) bus ();

      sync_fifo_v2 #(
         .FIFO_WIDTH(16),
         .FIFO_DEPTH(DEPTH),
         .AF_LEVEL(AF),
         .AE_LEVEL(AE)
      ) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );

      assign bus.wr_en   = wr_en;
      assign bus.rd_en   = rd_en;
      assign bus.data_in = data_in;

      logic [15:0] q[$];
      logic [15:0] last_rd = '0;
      exp_t        expq[$];

      // Reference: an unbounded queue capped at DEPTH, decisions taken on the size before the edge.
      always @(posedge clk) begin
         exp_t e;
         bit   wa;
         bit   ra;
         e = '0;
         if (rst) begin
            q.delete();
            last_rd = '0;
         end else begin
            wa    = wr_en && (q.size() < DEPTH);
            ra    = rd_en && (q.size() > 0);
            e.ack = wa;
            e.ovf = wr_en && (q.size() == DEPTH);
            e.unf = rd_en && (q.size() == 0);
            if (ra) last_rd = q.pop_front();
            if (wa) q.push_back(data_in);
         end
         e.cnt   = 8'(q.size());
         e.full  = (q.size() == DEPTH);
         e.empty = (q.size() == 0);
         e.af    = (q.size() >= AF) && (q.size() < DEPTH);
         e.ae    = (q.size() <= AE) && (q.size() > 0);
`ifdef FIFO_FWFT_EN
         e.dout  = (q.size() > 0) ? q[0] : 16'h0;
`else
         e.dout  = last_rd;
`endif
         expq.push_back(e);
      end

      always @(negedge clk) begin
         exp_t e;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("data_out",    DEPTH, 32'(bus.data_out),    32'(e.dout));
            chk("count",       DEPTH, 32'(bus.count),       32'(e.cnt));
            chk("full",        DEPTH, 32'(bus.full),        32'(e.full));
            chk("empty",       DEPTH, 32'(bus.empty),       32'(e.empty));
            chk("almostfull",  DEPTH, 32'(bus.almostfull),  32'(e.af));
            chk("almostempty", DEPTH, 32'(bus.almostempty), 32'(e.ae));
            chk("wr_ack",      DEPTH, 32'(bus.wr_ack),      32'(e.ack));
            chk("overflow",    DEPTH, 32'(bus.overflow),    32'(e.ovf));
            chk("underflow",   DEPTH, 32'(bus.underflow),   32'(e.unf));
         end
      end
   end

   task automatic drive(input bit w, input bit r, input logic [15:0] d, input bit rs = 1'b0);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      rst     = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b1, 16'hBEEF, 1'b1);
      drive(1'b0, 1'b0, 16'h0, 1'b1);

      // Fill past full, then drain past empty.
      for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 16'(i));
      drive(1'b1, 1'b0, 16'hAAAA);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 16'h0);
      drive(1'b0, 1'b0, 16'h0);

      // Steady state at count 4 with simultaneous traffic wraps the pointers.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0100 + 16'(i));
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 16'($urandom));
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 16'h0);

      // Both requests at full, then both at empty.
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'h0010 + 16'(i));
      drive(1'b1, 1'b1, 16'h5555);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 16'h0);
      drive(1'b1, 1'b1, 16'h6666);
      drive(1'b0, 1'b1, 16'h0);
      drive(1'b0, 1'b0, 16'h0);

      // Reset mid-burst with a write pending, then a clean write/read.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'h0020 + 16'(i));
      drive(1'b1, 1'b0, 16'h7777, 1'b1);
      drive(1'b1, 1'b0, 16'h1234);
      drive(1'b0, 1'b1, 16'h0);
      drive(1'b0, 1'b0, 16'h0);

      // Random traffic: write-biased half then read-biased half, rare resets.
      for (int i = 0; i < 400; i++) begin
         bit w;
         bit r;
         w = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         r = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive(w, r, 16'($urandom), ($urandom_range(0, 63) == 0));
      end
      drive(1'b0, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 16'h0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 8, 32'(g_cfg[0].expq.size()), 32'd0);
      chk("scoreboard_drained", 5, 32'(g_cfg[1].expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised single-clock FIFO, the next generation of the team's 16x8 FIFO. Generalises width and depth (depth need not be a power of two) and adds programmable almost-full/almost-empty levels and an occupancy count output. An optional first-word-fall-through read mode is selected at compile time. Sits between a producer and a consumer in the same clock domain and is the block the UVM FIFO environment targets next.

## Interface

- FIFO_WIDTH, 16: data word width in bits, ≥1
- FIFO_DEPTH, 8: number of entries, ≥2, any integer
- AF_LEVEL, FIFO_DEPTH-1: almostfull asserts when count ≥ AF_LEVEL and count < FIFO_DEPTH
- AE_LEVEL, 1: almostempty asserts when count ≤ AE_LEVEL and count > 0
- Legal range: 1 ≤ AE_LEVEL < AF_LEVEL ≤ FIFO_DEPTH-1; elaboration-time error otherwise
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_out  output  FIFO_WIDTH  read data
- wr_ack  output  1  previous-cycle write accepted
- overflow  output  1  previous-cycle write rejected (FIFO full)
- underflow  output  1  previous-cycle read rejected (FIFO empty)
- full, empty, almostfull, almostempty  output  1 each  occupancy flags
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy, 0..FIFO_DEPTH

## Operation

- Storage: FIFO_DEPTH x FIFO_WIDTH array; wr_ptr, rd_ptr width max($clog2(FIFO_DEPTH),1); each wraps from FIFO_DEPTH-1 to 0 (explicit compare, not natural overflow).
- Write accepted iff wr_en && !full: mem[wr_ptr] <= data_in, wr_ptr advances.
- Read accepted iff rd_en && !empty: rd_ptr advances.
- Acceptance uses flags as registered at the start of the cycle: with wr_en && rd_en at full only the read is accepted (overflow flagged); at empty only the write is accepted (underflow flagged); otherwise both accepted and count unchanged.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Flags decoded combinationally from count: full = (count == FIFO_DEPTH), empty = (count == 0); almostfull/almostempty per the parameter definitions above. Exactly one of empty/almostempty/neither and one of full/almostfull/neither hold at any time.
- wr_ack, overflow, underflow are registered one-cycle pulses; each is 0 in any cycle whose preceding edge had no matching event.
- Reset (any cycle, including mid-burst): wr_ptr, rd_ptr, count ← 0; data_out, wr_ack, overflow, underflow ← 0; hence empty = 1, all other flags 0. Memory contents are not cleared. Requests in the reset cycle are ignored and raise no status pulse.

## Timing

- Write latency: word written at edge N is readable (count/empty updated) after edge N.
- Standard read: data_out registered; loaded with mem[rd_ptr] at the edge accepting the read; holds value otherwise, including after rejected reads.
- Status pulses valid in the cycle after the triggering edge, for exactly one cycle.
- No combinational path from wr_en/rd_en/data_in to any output.

## Configuration

- FIFO_FWFT_EN defined: first-word-fall-through. data_out = mem[rd_ptr] combinationally whenever !empty, 0 when empty; rd_en acknowledges/pops the displayed word. A word written into an empty FIFO appears on data_out the cycle after its write edge.
- FIFO_FWFT_EN undefined: standard registered read as described in Timing (one-cycle read latency).
- All other behaviour identical in both modes.

## Test plan

- Reset then 8 writes 0x0001..0x0008 (DEPTH 8): wr_ack each cycle after; almostfull at count 7, full at count 8; 9th write 0xAAAA → overflow = 1 one cycle, count stays 8.
- From full, 8 reads: data_out 0x0001..0x0008 in order (cycle after each read, or pre-displayed in FWFT); almostempty at count 1, empty at 0; extra read → underflow = 1, data_out holds 0x0008 (standard) / 0 (FWFT).
- Simultaneous wr_en+rd_en at count 4 for 20 cycles: count stays 4, pointers wrap twice, data order preserved.
- Simultaneous wr_en+rd_en at full → read only, overflow = 1, count 7; at empty → write only, underflow = 1, count 1.
- FIFO_DEPTH 5, AF_LEVEL 3, AE_LEVEL 2: fill/drain shows almostfull at counts 3–4, almostempty at 1–2, wrap from pointer 4 to 0 correct.
- Assert rst at count 5 mid-burst with wr_en=1: next cycle count 0, empty 1, all pulses 0; subsequent write of 0x1234 reads back 0x1234.
